// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column drive, debounces one
// key per press and keeps the two most recent digits for the display mux.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 48000,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic       key_valid
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_d;
  logic [3:0]        rows_m, rows_s;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [1:0]        col_idx, col_idx_d;
  logic [1:0]        row_idx, row_idx_d;
  logic [1:0]        low_row;
  logic              row_bit;
  logic [3:0]        digit_left_d, digit_right_d;
  logic              key_valid_d;

  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Two-flop synchronizer; idle rows read high through the pull-ups.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_m <= 4'b1111;
      rows_s <= 4'b1111;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  // Lowest-numbered low row wins: iterate downwards so row 0 is assigned last.
  always_comb begin
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_s[r]) low_row = 2'(r);
    end
  end

  assign row_bit = rows_s[row_idx];

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state;
    scan_cnt_d    = scan_cnt;
    db_cnt_d      = db_cnt;
    col_idx_d     = col_idx;
    row_idx_d     = row_idx;
    digit_left_d  = digit_left;
    digit_right_d = digit_right;
    key_valid_d   = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rows_s != 4'b1111) begin
            row_idx_d = low_row;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_bit) begin
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          state_d    = SCAN;
        end else if (db_cnt == DB_LAST) begin
          db_cnt_d      = '0;
          digit_left_d  = digit_right;
          digit_right_d = decode_key(row_idx, col_idx);
          key_valid_d   = 1'b1;
          state_d       = HELD;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      HELD: begin
        if (row_bit) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
      end

      RELEASE: begin
        if (!row_bit) begin
          db_cnt_d = '0;
          state_d  = HELD;
        end else if (db_cnt == DB_LAST) begin
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          col_idx_d  = col_idx + 2'd1;
          state_d    = SCAN;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SCAN;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      cols        <= 4'b1110;
      digit_left  <= 4'h0;
      digit_right <= 4'h0;
      key_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      scan_cnt    <= scan_cnt_d;
      db_cnt      <= db_cnt_d;
      col_idx     <= col_idx_d;
      row_idx     <= row_idx_d;
      cols        <= ~(4'b0001 << col_idx_d);
      digit_left  <= digit_left_d;
      digit_right <= digit_right_d;
      key_valid   <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a scoreboard of expected
// {digit_left, digit_right} pairs popped on every key_valid pulse.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DB   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows, cols, digit_left, digit_right;
  logic       key_valid;
  logic [15:0] pressed = '0;

  int checks   = 0;
  int errors   = 0;
  int kv_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_pair;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .digit_left(digit_left), .digit_right(digit_right), .key_valid(key_valid)
  );

  // A pressed key shorts its row to its column; the row reads low only while that column is driven.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      kv_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        exp_pair = exp_q.pop_front();
        check("digits_on_key_valid", {24'd0, digit_left, digit_right}, {24'd0, exp_pair});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r*4+c] = v;
  endtask

  task automatic wait_cols(input logic [3:0] target, input string tag);
    int n = 0;
    while (cols !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {28'd0, cols}, {28'd0, target});
  endtask

  task automatic wait_kv(input int target, input int budget, input string tag);
    int n = 0;
    while (kv_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, kv_count, target);
  endtask

  task automatic tap(input int r, input int c, input int hold, input int gap);
    set_key(r, c, 1'b1);
    cycles(hold);
    set_key(r, c, 1'b0);
    cycles(gap);
  endtask

  logic [3:0] rot [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    reset = 1'b0;
    cycles(3);
    check("reset_cols", {28'd0, cols}, 32'hE);
    check("reset_digits", {24'd0, digit_left, digit_right}, 32'h00);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);

    // Idle rotation, one column every SCAN cycles.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle_rotation", {28'd0, cols}, {28'd0, rot[i]});
      cycles(SCAN);
    end

    // Single '5' held well past debounce.
    exp_q.push_back({4'h0, 4'h5});
    set_key(1, 1, 1'b1);
    cycles(40);
    check("cols_frozen_5", {28'd0, cols}, 32'hD);
    check("kv_count_held_5", kv_count, 1);
    set_key(1, 1, 1'b0);
    cycles(30);
    check("digits_after_5", {24'd0, digit_left, digit_right}, 32'h05);

    // '5' then '9'.
    exp_q.push_back({4'h5, 4'h5});
    tap(1, 1, 40, 30);
    exp_q.push_back({4'h5, 4'h9});
    tap(2, 2, 40, 30);
    check("digits_5_9", {24'd0, digit_left, digit_right}, 32'h59);
    check("kv_count_5_9", kv_count, 3);

    // Short 'D' glitch aligned to the column-3 sampling point.
    wait_cols(4'b1011, "align_col2");
    wait_cols(4'b0111, "align_col3");
    tap(3, 3, 3, 20);
    check("glitch_no_kv", kv_count, 3);
    check("glitch_digits", {24'd0, digit_left, digit_right}, 32'h59);
    wait_cols(4'b1110, "scan_resumes");

    // '1' held, '6' added while held, then a bouncy release of '1'.
    exp_q.push_back({4'h9, 4'h1});
    set_key(0, 0, 1'b1);
    cycles(40);
    set_key(1, 2, 1'b1);
    cycles(20);
    check("cols_frozen_1", {28'd0, cols}, 32'hE);
    set_key(1, 2, 1'b0);
    set_key(0, 0, 1'b0);
    cycles(3);
    set_key(0, 0, 1'b1);
    cycles(2);
    set_key(0, 0, 1'b0);
    cycles(40);
    check("bounce_kv_count", kv_count, 4);
    check("digits_1", {24'd0, digit_left, digit_right}, 32'h91);

    // Reset in the middle of debouncing 'A', key stays held.
    wait_cols(4'b1011, "align_a_col2");
    wait_cols(4'b0111, "align_a_col3");
    set_key(0, 3, 1'b1);
    cycles(6);
    reset = 1'b0;
    cycles(2);
    check("midreset_cols", {28'd0, cols}, 32'hE);
    check("midreset_digits", {24'd0, digit_left, digit_right}, 32'h00);
    check("midreset_key_valid", {31'd0, key_valid}, 32'd0);
    check("midreset_kv_count", kv_count, 4);
    exp_q.push_back({4'h0, 4'hA});
    reset = 1'b1;
    wait_kv(5, 80, "kv_after_reset");
    check("digits_a", {24'd0, digit_left, digit_right}, 32'h0A);
    check("cols_frozen_a", {28'd0, cols}, 32'h7);
    set_key(0, 3, 1'b0);
    cycles(30);
    check("final_kv_count", kv_count, 5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
